// File: rtl/reg_checkpoint_buffer.sv
// reg_checkpoint_buffer
//
// Holds register-file checkpoints for in-flight predicted branches. Decode
// allocates a checkpoint when it issues a predicted branch. A correct resolve
// of the oldest branch frees that checkpoint. A mispredict of the oldest
// branch latches its checkpoint onto regs_snapshot and runs a short
// handshake that restores the register file.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   take_snapshot       allocate a checkpoint this cycle
//   snap_tag            tag the allocation this cycle receives (tail pointer)
//   regs_in             flat register array, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wb_uses_rw/addr/data  same-cycle writeback, merged into a new checkpoint
//   resolve_valid/tag/mispredict  branch resolution from execute
//   recover_snapshot    one-cycle restore strobe to the register file
//   regs_snapshot       checkpoint being restored (same flat layout as regs_in)
//   rf_done             register file restore complete
//   recovery_done_ack   one-cycle recovery-complete pulse
//   full, empty         occupancy flags derived from the registered count
//   busy                recovery FSM is not idle
//   tag_error           sticky: out-of-order resolve, or resolve while empty
module reg_checkpoint_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           take_snapshot,
    output logic [$clog2(DEPTH)-1:0]       snap_tag,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] regs_in,
    input  logic                           wb_uses_rw,
    input  logic [4:0]                     wb_rw_addr,
    input  logic [DATA_WIDTH-1:0]          wb_rw_data,
    input  logic                           resolve_valid,
    input  logic [$clog2(DEPTH)-1:0]       resolve_tag,
    input  logic                           resolve_mispredict,
    output logic                           recover_snapshot,
    output logic [DATA_WIDTH*NUM_REGS-1:0] regs_snapshot,
    input  logic                           rf_done,
    output logic                           recovery_done_ack,
    output logic                           full,
    output logic                           empty,
    output logic                           busy,
    output logic                           tag_error
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int FLAT = DATA_WIDTH * NUM_REGS;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        WAIT_DONE,
        ACK
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [FLAT-1:0] slots [DEPTH];
    logic [FLAT-1:0] merged;

    logic idle;
    logic tag_ok;
    logic do_pop;
    logic do_mispredict;
    logic do_alloc;
    logic bad_resolve;

    assign snap_tag = tail;
    assign full     = (count == CNT_DEPTH);
    assign empty    = (count == '0);
    assign idle     = (state == IDLE);

    // Only the oldest branch may resolve. Anything else is a protocol error.
    assign tag_ok        = resolve_valid && (resolve_tag == head) && !empty;
    assign do_pop        = idle && tag_ok && !resolve_mispredict;
    assign do_mispredict = idle && tag_ok && resolve_mispredict;
    assign bad_resolve   = idle && resolve_valid && (empty || (resolve_tag != head));

    // A pop in the same cycle frees the head slot, so allocation is allowed
    // even when full. When full, tail equals head, so the new checkpoint
    // lands in the slot being freed.
    assign do_alloc = idle && take_snapshot && !do_mispredict && (!full || do_pop);

    // Fold the same-cycle writeback into the captured array. The register
    // file has not committed it yet when regs_in is sampled. R0 is hardwired
    // to zero and is never merged.
    always_comb begin
        merged = regs_in;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_uses_rw && (wb_rw_addr == 5'(i))) begin
                merged[i*DATA_WIDTH +: DATA_WIDTH] = wb_rw_data;
            end
        end
    end

    // The checkpoint storage has no reset. Slots are valid only between
    // head and tail, and reset clears the pointers.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            slots[tail] <= merged;
        end
    end

    // Pointer and occupancy bookkeeping. Leaving ACK flushes every checkpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (state == ACK) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_pop) begin
                head <= head + PTR_ONE;
            end
            if (do_alloc) begin
                tail <= tail + PTR_ONE;
            end
            case ({do_alloc, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The restored checkpoint is held until the next mispredict so the
    // register file can sample it at any point during the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_snapshot <= '0;
        end else if (do_mispredict) begin
            regs_snapshot <= slots[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_error <= 1'b0;
        end else if (bad_resolve) begin
            tag_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Recovery sequence: RECOVER strobes the restore, WAIT_DONE waits for the
    // register file, and ACK reports completion while the buffer flushes.
    always_comb begin
        state_next        = state;
        recover_snapshot  = 1'b0;
        recovery_done_ack = 1'b0;
        busy              = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (do_mispredict) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                recover_snapshot = 1'b1;
                state_next       = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rf_done) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                recovery_done_ack = 1'b1;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_checkpoint_buffer.sv
// tb_reg_checkpoint_buffer
//
// Directed testbench for reg_checkpoint_buffer. Each task drives one scenario
// and compares outputs against values worked out by hand. Inputs change 1ns
// after the rising edge. Outputs are sampled at that point, after the edge
// has settled.
module tb_reg_checkpoint_buffer;

    localparam int DW    = 32;
    localparam int NR    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int FLAT  = DW * NR;

    logic            clk;
    logic            rst_n;
    logic            take_snapshot;
    logic [TW-1:0]   snap_tag;
    logic [FLAT-1:0] regs_in;
    logic            wb_uses_rw;
    logic [4:0]      wb_rw_addr;
    logic [DW-1:0]   wb_rw_data;
    logic            resolve_valid;
    logic [TW-1:0]   resolve_tag;
    logic            resolve_mispredict;
    logic            recover_snapshot;
    logic [FLAT-1:0] regs_snapshot;
    logic            rf_done;
    logic            recovery_done_ack;
    logic            full;
    logic            empty;
    logic            busy;
    logic            tag_error;

    int checks;
    int errors;

    reg_checkpoint_buffer #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .take_snapshot     (take_snapshot),
        .snap_tag          (snap_tag),
        .regs_in           (regs_in),
        .wb_uses_rw        (wb_uses_rw),
        .wb_rw_addr        (wb_rw_addr),
        .wb_rw_data        (wb_rw_data),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .recover_snapshot  (recover_snapshot),
        .regs_snapshot     (regs_snapshot),
        .rf_done           (rf_done),
        .recovery_done_ack (recovery_done_ack),
        .full              (full),
        .empty             (empty),
        .busy              (busy),
        .tag_error         (tag_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register i holds base + i.
    function automatic logic [FLAT-1:0] pattern(input logic [DW-1:0] base);
        logic [FLAT-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i*DW +: DW] = base + DW'(i);
        end
        return v;
    endfunction

    // First register whose value differs, so a failing line stays short.
    function automatic int first_diff(input logic [FLAT-1:0] a, input logic [FLAT-1:0] b);
        for (int i = 0; i < NR; i++) begin
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        take_snapshot      = 1'b0;
        regs_in            = '0;
        wb_uses_rw         = 1'b0;
        wb_rw_addr         = '0;
        wb_rw_data         = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        rf_done            = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic take(input logic [FLAT-1:0] regs);
        regs_in       = regs;
        take_snapshot = 1'b1;
        tick();
        take_snapshot = 1'b0;
    endtask

    task automatic resolve(input logic [TW-1:0] tag, input logic mis);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_mispredict = mis;
        tick();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        logic [FLAT-1:0] zero;
        zero = '0;
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({recover_snapshot, recovery_done_ack, full, empty, busy, tag_error} !== 6'b000100) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rec=%b ack=%b full=%b empty=%b busy=%b terr=%b expected 0 0 0 1 0 0",
                     recover_snapshot, recovery_done_ack, full, empty, busy, tag_error);
        end
        checks++;
        if (snap_tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_snap_tag: got %0d expected 0", snap_tag);
        end
        checks++;
        if (regs_snapshot !== zero) begin
            errors++;
            $display("[TB] FAIL reset_regs_snapshot: nonzero, reg %0d = %h", first_diff(regs_snapshot, zero),
                     regs_snapshot[first_diff(regs_snapshot, zero)*DW +: DW]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alloc_basic();
        logic [FLAT-1:0] exp;
        do_reset();
        exp = pattern(32'd0);
        regs_in       = exp;
        take_snapshot = 1'b1;
        #1;
        checks++;
        if (snap_tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL alloc_tag_before_edge: got %0d expected 0", snap_tag);
        end
        tick();
        checks++;
        if (snap_tag !== 2'd1) begin
            errors++;
            $display("[TB] FAIL alloc_second_tag: got %0d expected 1", snap_tag);
        end
        take_snapshot = 1'b0;
        regs_in       = pattern(32'h5555_0000);
        checks++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alloc_count1_flags: got empty=%b full=%b expected 0 0", empty, full);
        end
        tick();
        resolve(2'd0, 1'b1);
        checks++;
        if (regs_snapshot !== exp) begin
            errors++;
            $display("[TB] FAIL alloc_snapshot_contents: reg %0d got %h expected %h",
                     first_diff(regs_snapshot, exp), regs_snapshot[first_diff(regs_snapshot, exp)*DW +: DW],
                     exp[first_diff(regs_snapshot, exp)*DW +: DW]);
        end
    endtask

    task automatic test_full_wrap();
        logic [FLAT-1:0] exp;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            take(pattern(32'h100 * (k + 1)));
        end
        checks++;
        if (full !== 1'b1 || snap_tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL full_after_four: got full=%b tag=%0d expected 1 0", full, snap_tag);
        end
        take(pattern(32'h900));
        checks++;
        if (full !== 1'b1 || snap_tag !== 2'd0 || empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drop: got full=%b tag=%0d empty=%b expected 1 0 0", full, snap_tag, empty);
        end
        exp = pattern(32'hA00);
        regs_in            = exp;
        take_snapshot      = 1'b1;
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd0;
        resolve_mispredict = 1'b0;
        tick();
        clear_inputs();
        checks++;
        if (full !== 1'b1 || snap_tag !== 2'd1) begin
            errors++;
            $display("[TB] FAIL full_pop_and_take: got full=%b tag=%0d expected 1 1", full, snap_tag);
        end
        resolve(2'd1, 1'b0);
        resolve(2'd2, 1'b0);
        resolve(2'd3, 1'b0);
        checks++;
        if (full !== 1'b0 || empty !== 1'b0 || tag_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_pops: got full=%b empty=%b terr=%b expected 0 0 0", full, empty, tag_error);
        end
        resolve(2'd0, 1'b1);
        checks++;
        if (regs_snapshot !== exp) begin
            errors++;
            $display("[TB] FAIL wrap_slot_contents: reg %0d got %h expected %h",
                     first_diff(regs_snapshot, exp), regs_snapshot[first_diff(regs_snapshot, exp)*DW +: DW],
                     exp[first_diff(regs_snapshot, exp)*DW +: DW]);
        end
    endtask

    task automatic test_wb_merge();
        logic [FLAT-1:0] exp;
        do_reset();
        exp = pattern(32'h1000);
        exp[5*DW +: DW] = 32'hDEAD_BEEF;
        wb_uses_rw = 1'b1;
        wb_rw_addr = 5'd5;
        wb_rw_data = 32'hDEAD_BEEF;
        take(pattern(32'h1000));
        wb_uses_rw = 1'b0;
        resolve(2'd0, 1'b1);
        checks++;
        if (regs_snapshot !== exp) begin
            errors++;
            $display("[TB] FAIL wb_merge_r5: reg %0d got %h expected %h",
                     first_diff(regs_snapshot, exp), regs_snapshot[first_diff(regs_snapshot, exp)*DW +: DW],
                     exp[first_diff(regs_snapshot, exp)*DW +: DW]);
        end
        do_reset();
        exp = pattern(32'h2000);
        wb_uses_rw = 1'b1;
        wb_rw_addr = 5'd0;
        wb_rw_data = 32'h1234_5678;
        take(exp);
        wb_uses_rw = 1'b0;
        resolve(2'd0, 1'b1);
        checks++;
        if (regs_snapshot !== exp) begin
            errors++;
            $display("[TB] FAIL wb_r0_not_merged: reg %0d got %h expected %h",
                     first_diff(regs_snapshot, exp), regs_snapshot[first_diff(regs_snapshot, exp)*DW +: DW],
                     exp[first_diff(regs_snapshot, exp)*DW +: DW]);
        end
    endtask

    task automatic test_mispredict_latency();
        logic [FLAT-1:0] exp;
        do_reset();
        exp = pattern(32'h3000);
        take(exp);
        take(pattern(32'h4000));
        // Cycle 0: mispredict of the head plus a take that must be ignored.
        regs_in            = pattern(32'h7000);
        take_snapshot      = 1'b1;
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd0;
        resolve_mispredict = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (recover_snapshot !== 1'b1 || busy !== 1'b1 || recovery_done_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_cycle1: got rec=%b busy=%b ack=%b expected 1 1 0",
                     recover_snapshot, busy, recovery_done_ack);
        end
        tick();
        checks++;
        if (recover_snapshot !== 1'b0 || busy !== 1'b1 || recovery_done_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_cycle2: got rec=%b busy=%b ack=%b expected 0 1 0",
                     recover_snapshot, busy, recovery_done_ack);
        end
        rf_done       = 1'b1;
        resolve_valid = 1'b1;
        resolve_tag   = 2'd3;
        tick();
        clear_inputs();
        checks++;
        if (recovery_done_ack !== 1'b1 || busy !== 1'b1 || tag_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_cycle3: got ack=%b busy=%b terr=%b expected 1 1 0",
                     recovery_done_ack, busy, tag_error);
        end
        tick();
        checks++;
        if (recovery_done_ack !== 1'b0 || busy !== 1'b0 || empty !== 1'b1 || snap_tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lat_cycle4: got ack=%b busy=%b empty=%b tag=%0d expected 0 0 1 0",
                     recovery_done_ack, busy, empty, snap_tag);
        end
        checks++;
        if (regs_snapshot !== exp) begin
            errors++;
            $display("[TB] FAIL lat_snapshot_hold: reg %0d got %h expected %h",
                     first_diff(regs_snapshot, exp), regs_snapshot[first_diff(regs_snapshot, exp)*DW +: DW],
                     exp[first_diff(regs_snapshot, exp)*DW +: DW]);
        end
    endtask

    task automatic test_tag_error();
        do_reset();
        resolve(2'd0, 1'b0);
        checks++;
        if (tag_error !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL terr_empty_resolve: got terr=%b empty=%b expected 1 1", tag_error, empty);
        end
        tick();
        tick();
        checks++;
        if (tag_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL terr_sticky: got %b expected 1", tag_error);
        end
        do_reset();
        take(pattern(32'h5000));
        checks++;
        if (tag_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL terr_clear_after_reset: got %b expected 0", tag_error);
        end
        resolve(2'd1, 1'b1);
        checks++;
        if (tag_error !== 1'b1 || busy !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL terr_wrong_tag: got terr=%b busy=%b empty=%b expected 1 0 0",
                     tag_error, busy, empty);
        end
        resolve(2'd0, 1'b0);
        checks++;
        if (tag_error !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL terr_then_pop: got terr=%b empty=%b expected 1 1", tag_error, empty);
        end
    endtask

    task automatic test_reset_mid_recovery();
        logic [FLAT-1:0] zero;
        zero = '0;
        do_reset();
        take(pattern(32'h6000));
        resolve(2'd0, 1'b1);
        tick();
        checks++;
        if (busy !== 1'b1 || recover_snapshot !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_in_wait: got busy=%b rec=%b expected 1 0", busy, recover_snapshot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || recover_snapshot !== 1'b0 || recovery_done_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got busy=%b empty=%b rec=%b ack=%b expected 0 1 0 0",
                     busy, empty, recover_snapshot, recovery_done_ack);
        end
        checks++;
        if (regs_snapshot !== zero) begin
            errors++;
            $display("[TB] FAIL midrst_snapshot_cleared: reg %0d = %h expected 0",
                     first_diff(regs_snapshot, zero), regs_snapshot[first_diff(regs_snapshot, zero)*DW +: DW]);
        end
        tick();
        rst_n   = 1'b1;
        rf_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (recovery_done_ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_no_ack_c%0d: got ack=%b busy=%b expected 0 0",
                         c, recovery_done_ack, busy);
            end
        end
        rf_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_alloc_basic();
        test_full_wrap();
        test_wb_merge();
        test_mispredict_latency();
        test_tag_error();
        test_reset_mid_recovery();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
